// File: rtl/req_pend_sched_pkg.sv
// Shared widths, the position-code type and constants for the request
// pending scheduler.
package sched_pkg;
    localparam int NREQ  = 4;
    localparam int POS_W = 3;
    localparam int GAP_W = 4;

    typedef logic [POS_W-1:0] pos_t;

    localparam pos_t POS_NONE = '0;
endpackage

// File: rtl/req_pend_sched_if.sv
// Request, clear and grant handshake bundle between the scheduler and its
// requesters and consumer.
interface req_pend_sched_if;
    import sched_pkg::*;

    logic [NREQ-1:0] req_in;
    logic            clr;
    logic            gnt_valid;
    pos_t            gnt_pos;
    logic            gnt_ready;
    logic [NREQ-1:0] pend;
    logic            overflow;

    // master is the scheduler side; slave is the requester/consumer side
    modport master (
        input  req_in, clr, gnt_ready,
        output gnt_valid, gnt_pos, pend, overflow
    );

    modport slave (
        output req_in, clr, gnt_ready,
        input  gnt_valid, gnt_pos, pend, overflow
    );
endinterface

// File: rtl/req_pend_sched_prio_enc4.sv
// Combinational highest-bit-first encoder: 0 when empty, k for bit k-1.
module prio_enc4
    import sched_pkg::*;
(
    input  logic [NREQ-1:0] vec_i,
    output pos_t            pos_o
);
    always_comb begin
        pos_o = POS_NONE;
        if (vec_i[3])      pos_o = pos_t'(4);
        else if (vec_i[2]) pos_o = pos_t'(3);
        else if (vec_i[1]) pos_o = pos_t'(2);
        else if (vec_i[0]) pos_o = pos_t'(1);
    end
endmodule

// File: rtl/req_pend_sched.sv
// Sticky request capture with highest-line-first grant draining over a
// registered valid/ready slot and an optional idle gap between grants.
module req_pend_sched
    import sched_pkg::*;
#(
    parameter int unsigned IDLE_GAP = 0
) (
    input  logic               clk,
    input  logic               rst_n,
    req_pend_sched_if.master   bus
);
    logic [NREQ-1:0]  pend_q, pend_d;
    logic             overflow_q, overflow_d;
    logic             valid_q, valid_d;
    pos_t             pos_q, pos_d;
    logic [GAP_W-1:0] gap_q, gap_d;

    pos_t             encPos;
    logic             handshake;
    logic             slotFree;
    logic             load;
    logic [NREQ-1:0]  loadMask;

    prio_enc4 u_enc (
        .vec_i (pend_q),
        .pos_o (encPos)
    );

    // The load gate looks at the counter's next value so that the last
    // decrement edge can already load, giving exactly IDLE_GAP idle cycles.
    always_comb begin
        handshake = valid_q && bus.gnt_ready;
        slotFree  = !valid_q || bus.gnt_ready;

        gap_d = gap_q;
        if (handshake)
            gap_d = GAP_W'(IDLE_GAP);
        else if (gap_q != '0)
            gap_d = gap_q - 1'b1;

        load = slotFree && (gap_d == '0) && (pend_q != '0) && !bus.clr;

        loadMask = '0;
        for (int i = 0; i < NREQ; i++)
            loadMask[i] = load && (encPos == pos_t'(i + 1));

        valid_d = valid_q;
        pos_d   = pos_q;
        if (load) begin
            valid_d = 1'b1;
            pos_d   = encPos;
        end else if (slotFree) begin
            valid_d = 1'b0;
            pos_d   = POS_NONE;
        end

        if (bus.clr) begin
            pend_d     = bus.req_in;
            overflow_d = 1'b0;
        end else begin
            pend_d     = (pend_q & ~loadMask) | bus.req_in;
            overflow_d = overflow_q | (|(bus.req_in & pend_q & ~loadMask));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q     <= '0;
            overflow_q <= 1'b0;
            valid_q    <= 1'b0;
            pos_q      <= POS_NONE;
            gap_q      <= '0;
        end else begin
            pend_q     <= pend_d;
            overflow_q <= overflow_d;
            valid_q    <= valid_d;
            pos_q      <= pos_d;
            gap_q      <= gap_d;
        end
    end

    assign bus.pend      = pend_q;
    assign bus.overflow  = overflow_q;
    assign bus.gnt_valid = valid_q;
    assign bus.gnt_pos   = pos_q;
endmodule

// File: tb/tb_req_pend_sched.sv
// Directed bench for req_pend_sched: one instance with no idle gap and one
// with a gap of three cycles.
module tb_req_pend_sched;
    import sched_pkg::*;

    logic clk;
    logic rst_n;
    int   checkCount;
    int   errorCount;

    req_pend_sched_if bus0 ();
    req_pend_sched_if bus3 ();

    req_pend_sched #(.IDLE_GAP(0)) dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus0.master)
    );

    req_pend_sched #(.IDLE_GAP(3)) dut3 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus3.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [7:0] observed,
                               input logic [7:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s got %0d expected %0d", tag, observed, expected);
        end
    endtask

    // Drive one cycle of inputs on the zero-gap instance and step to 1 ns
    // after the following rising edge.
    task automatic applyStimulus(input logic [3:0] req, input logic clr,
                                 input logic ready);
        bus0.req_in    = req;
        bus0.clr       = clr;
        bus0.gnt_ready = ready;
        @(posedge clk);
        #1;
    endtask

    task automatic checkState0(input string tag, input logic valid,
                               input logic [2:0] pos, input logic [3:0] pend);
        checkOutput({tag, "_valid"}, 8'(bus0.gnt_valid), 8'(valid));
        if (valid)
            checkOutput({tag, "_pos"}, 8'(bus0.gnt_pos), 8'(pos));
        checkOutput({tag, "_pend"}, 8'(bus0.pend), 8'(pend));
    endtask

    initial begin
        checkCount     = 0;
        errorCount     = 0;
        rst_n          = 1'b0;
        bus0.req_in    = '0;
        bus0.clr       = 1'b0;
        bus0.gnt_ready = 1'b0;
        bus3.req_in    = '0;
        bus3.clr       = 1'b0;
        bus3.gnt_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        checkOutput("rst_valid", 8'(bus0.gnt_valid), 8'd0);
        checkOutput("rst_pos", 8'(bus0.gnt_pos), 8'd0);
        checkOutput("rst_pend", 8'(bus0.pend), 8'd0);
        checkOutput("rst_ovf", 8'(bus0.overflow), 8'd0);

        // Two requests drain highest first back to back
        applyStimulus(4'b0101, 1'b0, 1'b1);
        checkState0("basic_cap", 1'b0, 3'd0, 4'b0101);
        applyStimulus(4'b0000, 1'b0, 1'b1);
        checkState0("basic_g1", 1'b1, 3'd3, 4'b0001);
        applyStimulus(4'b0000, 1'b0, 1'b1);
        checkState0("basic_g2", 1'b1, 3'd1, 4'b0000);
        applyStimulus(4'b0000, 1'b0, 1'b1);
        checkState0("basic_idle", 1'b0, 3'd0, 4'b0000);

        // Back-pressure holds the grant while a new request is captured
        applyStimulus(4'b1000, 1'b0, 1'b0);
        checkState0("bp_cap", 1'b0, 3'd0, 4'b1000);
        applyStimulus(4'b0000, 1'b0, 1'b0);
        checkState0("bp_load", 1'b1, 3'd4, 4'b0000);
        applyStimulus(4'b0010, 1'b0, 1'b0);
        checkState0("bp_stall_req", 1'b1, 3'd4, 4'b0010);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(4'b0000, 1'b0, 1'b0);
            checkState0("bp_hold", 1'b1, 3'd4, 4'b0010);
        end
        applyStimulus(4'b0000, 1'b0, 1'b1);
        checkState0("bp_next", 1'b1, 3'd2, 4'b0000);
        applyStimulus(4'b0000, 1'b0, 1'b1);
        checkState0("bp_idle", 1'b0, 3'd0, 4'b0000);

        // A higher line arriving during a stall overtakes the lower pending one
        applyStimulus(4'b1001, 1'b0, 1'b0);
        checkState0("ot_cap", 1'b0, 3'd0, 4'b1001);
        applyStimulus(4'b0000, 1'b0, 1'b0);
        checkState0("ot_load", 1'b1, 3'd4, 4'b0001);
        applyStimulus(4'b0100, 1'b0, 1'b0);
        checkState0("ot_inject", 1'b1, 3'd4, 4'b0101);
        applyStimulus(4'b0000, 1'b0, 1'b1);
        checkState0("ot_g3", 1'b1, 3'd3, 4'b0001);
        applyStimulus(4'b0000, 1'b0, 1'b1);
        checkState0("ot_g1", 1'b1, 3'd1, 4'b0000);
        applyStimulus(4'b0000, 1'b0, 1'b1);
        checkState0("ot_idle", 1'b0, 3'd0, 4'b0000);

        // Overflow, clear and the same-cycle load/set case
        applyStimulus(4'b1100, 1'b0, 1'b0);
        applyStimulus(4'b0000, 1'b0, 1'b0);
        checkState0("ov_stall", 1'b1, 3'd4, 4'b0100);
        applyStimulus(4'b0100, 1'b0, 1'b0);
        checkOutput("ov_set", 8'(bus0.overflow), 8'd1);
        applyStimulus(4'b0100, 1'b1, 1'b0);
        checkOutput("ov_clr", 8'(bus0.overflow), 8'd0);
        checkState0("ov_clr_state", 1'b1, 3'd4, 4'b0100);
        applyStimulus(4'b0100, 1'b0, 1'b1);
        checkState0("ov_reload", 1'b1, 3'd3, 4'b0100);
        checkOutput("ov_noset", 8'(bus0.overflow), 8'd0);
        applyStimulus(4'b0000, 1'b1, 1'b1);
        checkState0("clr_noload", 1'b0, 3'd0, 4'b0000);

        // Idle gap of three cycles on the second instance
        bus3.req_in = 4'b0011;
        @(posedge clk);
        #1;
        bus3.req_in = 4'b0000;
        @(posedge clk);
        #1;
        checkOutput("gap_g1_valid", 8'(bus3.gnt_valid), 8'd1);
        checkOutput("gap_g1_pos", 8'(bus3.gnt_pos), 8'd2);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            checkOutput("gap_idle", 8'(bus3.gnt_valid), 8'd0);
        end
        @(posedge clk);
        #1;
        checkOutput("gap_g2_valid", 8'(bus3.gnt_valid), 8'd1);
        checkOutput("gap_g2_pos", 8'(bus3.gnt_pos), 8'd1);

        // Asynchronous reset with a live grant and pending bits
        applyStimulus(4'b0100, 1'b0, 1'b0);
        applyStimulus(4'b0000, 1'b0, 1'b0);
        applyStimulus(4'b1010, 1'b0, 1'b0);
        checkState0("ar_pre", 1'b1, 3'd3, 4'b1010);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("ar_valid", 8'(bus0.gnt_valid), 8'd0);
        checkOutput("ar_pos", 8'(bus0.gnt_pos), 8'd0);
        checkOutput("ar_pend", 8'(bus0.pend), 8'd0);
        checkOutput("ar_ovf", 8'(bus0.overflow), 8'd0);
        #2;
        rst_n = 1'b1;
        applyStimulus(4'b0000, 1'b0, 1'b1);
        checkState0("ar_after1", 1'b0, 3'd0, 4'b0000);
        applyStimulus(4'b0000, 1'b0, 1'b1);
        checkState0("ar_after2", 1'b0, 3'd0, 4'b0000);

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end
endmodule

// File: doc/req_pend_sched.md
# req_pend_sched

Captures single-cycle request pulses on 4 lines into a sticky pending vector. Drains them one at a time as registered grant codes over a valid/ready handshake, highest-numbered pending line first. It sits directly upstream of the consumer that takes a 3-bit position code. That code is 0 for none and k for line k-1. This block produces that code from held request state, applies back-pressure, and can enforce a minimum idle gap between grants.

## Interface
- IDLE_GAP, default 0: minimum idle cycles after a grant handshake before the next grant may load. Legal range is 0..15.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- req_in  in  4  request pulses. Bit i high at a clock edge sets pending bit i.
- clr  in  1  synchronous clear of the pending vector and overflow.
- gnt_valid  out  1  grant code available.
- gnt_pos  out  3  grant code. The value is 1..4 for line 0..3 and is valid only when gnt_valid is high.
- gnt_ready  in  1  consumer accepts gnt_pos this cycle.
- pend  out  4  current pending vector (registered).
- overflow  out  1  sticky flag: a request hit a bit that was already pending.

## Operation
- Reset values: pend=0, gnt_valid=0, gnt_pos=0, overflow=0, gap counter=0.
- Encode: enc = position of the highest set bit of pend, plus 1. The value is 0 when pend=0. Example: 4'b0101 gives 3; 4'b1111 gives 4.
- Output slot is free when gnt_valid=0, or when gnt_valid and gnt_ready are both high.
- Load condition: slot free, gap counter=0, pend≠0, and clr=0.
- On load: gnt_pos←enc, gnt_valid←1, and pend bit (enc-1) is cleared.
- If the slot is free and no load occurs, gnt_valid←0.
- While gnt_valid=1 and gnt_ready=0, gnt_pos is held stable.
- Next pending value, in order:
  - take pend,
  - clear the loaded bit,
  - OR in req_in.
  - A set by req_in wins over the same-cycle clear.
- clr=1:
  - pend←req_in and overflow←0.
  - No load happens in that cycle.
  - An already-valid grant is unaffected and still completes its handshake.
- overflow: set when req_in[i]=1 and pend[i]=1 and bit i is not being loaded in that cycle. It clears only on clr or reset.
- Gap counter:
  - On a handshake (gnt_valid and gnt_ready), it loads IDLE_GAP.
  - Otherwise it decrements when nonzero.
  - A handshake and a load in the same cycle are only possible when IDLE_GAP=0.
- Gap counter width is 4 bits. It saturates at 0 and never wraps.

## Timing
- Latency: req_in high at edge E puts the bit in pend after E. The earliest gnt_valid is after edge E+1, which is 2 cycles.
- Throughput with IDLE_GAP=0 and gnt_ready held high: one grant per cycle, with no bubble between grants.
- With IDLE_GAP=G: after the handshake edge, gnt_valid is low for exactly G cycles. The next grant then appears after G+1 edges.
- Priority is re-evaluated on every load. A higher line that arrives while a lower line is still pending is granted first.
- Asynchronous reset mid-operation: all outputs go to their reset values immediately. Pending requests are lost.
- All outputs are registered. There is no combinational path from req_in or gnt_ready to any output.

## Structure
- Package sched_pkg holds:
  - localparam NREQ=4 and POS_W=3,
  - typedef logic [POS_W-1:0] pos_t,
  - localparam pos_t POS_NONE=0,
  - localparam GAP_W=4.
- Sub-module prio_enc4 is a purely combinational 4-bit to pos_t encoder, highest bit first. It is instantiated once on pend.
- The top level contains the pending register, overflow flag, output slot, and gap counter. No further hierarchy.

## Test plan
- Reset, then req_in=4'b0101 for 1 cycle with gnt_ready=1 and IDLE_GAP=0:
  - gnt_pos=3 then 1 on consecutive cycles,
  - then gnt_valid=0 and pend=0.
- Back-pressure: pend=4'b1000 and gnt_ready=0 for 5 cycles:
  - gnt_valid=1 and gnt_pos=4 are held stable.
  - req_in=4'b0010 during the stall; after ready, the next grant is 2.
- Priority overtake: pend=4'b0001 with a grant stalled; inject req_in=4'b0100. The order after the current grant is 3, then 1.
- Overflow and same-cycle cases:
  - req_in[2] while pend[2]=1 and not loading gives overflow=1.
  - req_in[2] in the cycle bit 2 is loaded gives pend[2]=1 and overflow stays 0.
  - clr then gives overflow=0.
- IDLE_GAP=3, pend=4'b0011, gnt_ready=1: gnt_valid is high for 1 cycle, low for 3, then high with gnt_pos=1.
- Asynchronous reset asserted mid-stream with gnt_valid=1 and pend=4'b1010: all outputs are 0 before the next clock edge. After release, no grant appears without new requests.
